// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier peripheral: register map,
// CTRL bit positions and the core FSM encoding.
package mult_pkg;

  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_RES_LO = 3'd3;
  localparam logic [2:0] ADDR_RES_HI = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_core.sv
// Iterative shift-add datapath: magnitudes are multiplied unsigned over exactly
// WIDTH RUN cycles, then the sign is applied once in FIX.
module mult_core
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  mag_a_s, mag_b_s;

  // Magnitude of -2^(W-1) wraps to itself, which is the correct unsigned value.
  assign mag_a_s = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign mag_b_s = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // Next-state and datapath update for LOAD/RUN/FIX.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        mcand_d = PW'(mag_a_s);
        mplr_d  = mag_b_s;
        neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        else           acc_d = acc_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        else                         state_d = ST_RUN;
      end
      ST_FIX: begin
        if (neg_q) product_d = ~acc_q + PW'(1);
        else       product_d = acc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = (state_q == ST_FIX);
  assign product    = product_q;

endmodule

// File: rtl/multiplier_shift_add.sv
// Bus-facing wrapper: operand/control registers, read mux, CPU stall signals
// and LED output around the iterative multiplier core.
module multiplier_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LED_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wstrb,
  input  logic              rstrb,
  input  logic [2:0]        sel,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              wbusy,
  output logic              rbusy,
  output logic [LED_W-1:0]  LED
);

  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                signed_q, signed_d;
  logic                done_q, done_d;
  logic                busy_s, done_pulse_s, wr_en_s, start_s;
  logic [2*WIDTH-1:0]  product_s;
  logic                unused_wdata_s;

  // Writes during a run are dropped so operands stay stable for the core.
  assign wr_en_s        = wstrb & ~busy_s;
  assign start_s        = wr_en_s & (sel == ADDR_CTRL) & wdata[CTRL_START];
  assign unused_wdata_s = ^wdata;

  mult_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
    .signed_mode (signed_q),
    .a           (a_q),
    .b           (b_q),
    .busy        (busy_s),
    .done_pulse  (done_pulse_s),
    .product     (product_s)
  );

  // Register-bank next values.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    if (wr_en_s) begin
      case (sel)
        ADDR_A:    a_d      = wdata[WIDTH-1:0];
        ADDR_B:    b_d      = wdata[WIDTH-1:0];
        ADDR_CTRL: signed_d = wdata[CTRL_SIGNED];
        default:   a_d      = a_q;
      endcase
    end else begin
      signed_d = signed_q;
    end
    if (start_s)           done_d = 1'b0;
    else if (done_pulse_s) done_d = 1'b1;
    else                   done_d = done_q;
  end

  // Register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      done_q   <= done_d;
    end
  end

  // Read mux; every field is zero-extended to the bus width.
  always_comb begin
    case (sel)
      ADDR_A:      rdata = 32'(a_q);
      ADDR_B:      rdata = 32'(b_q);
      ADDR_CTRL:   rdata = {30'd0, signed_q, 1'b0};
      ADDR_RES_LO: rdata = 32'(product_s[WIDTH-1:0]);
      ADDR_RES_HI: rdata = 32'(product_s[2*WIDTH-1:WIDTH]);
      ADDR_STATUS: rdata = {30'd0, done_q, busy_s};
      default:     rdata = 32'd0;
    endcase
  end

  assign wbusy = busy_s & wstrb;
  assign rbusy = busy_s & rstrb & ((sel == ADDR_RES_LO) | (sel == ADDR_RES_HI));
  assign LED   = product_s[LED_W-1:0];

endmodule
